// File: rtl/sudoku_onehot_stream.sv
// Streaming one-hot to binary cell decoder with a registered output stage,
// per-cell framing over an N x N grid and end-of-frame blank/illegal totals.
module sudoku_onehot_stream #(
    parameter int N     = 9,
    parameter int CELLS = N * N,
    parameter int VAL_W = $clog2(N + 1),
    parameter int IDX_W = $clog2(CELLS),
    parameter int CNT_W = $clog2(CELLS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_cell,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VAL_W-1:0] out_value,
    output logic             out_err,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             frame_done,
    output logic [CNT_W-1:0] blank_count,
    output logic [CNT_W-1:0] err_count
);

    // Handshake: a cell transfers on a rising edge where in_valid && in_ready;
    // a beat transfers where out_valid && out_ready. in_ready is high whenever
    // the output register is empty or being drained in the same cycle.

    logic             accept;
    logic             last_cell;
    logic             dec_blank;
    logic             dec_multi;
    logic             dec_seen;
    logic [VAL_W-1:0] dec_val;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] blank_acc_q, blank_acc_d;
    logic [CNT_W-1:0] err_acc_q, err_acc_d;
    logic [CNT_W-1:0] blank_count_q, blank_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             out_valid_q, out_valid_d;
    logic [VAL_W-1:0] out_value_q, out_value_d;
    logic             out_err_q, out_err_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic             out_last_q, out_last_d;
    logic             frame_done_q, frame_done_d;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign last_cell = (idx_q == IDX_W'(CELLS - 1));

    // The lowest set bit sets the digit; any further set bit marks the cell illegal.
    always_comb begin
        dec_val   = '0;
        dec_multi = 1'b0;
        dec_seen  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (in_cell[k]) begin
                if (dec_seen) begin
                    dec_multi = 1'b1;
                end else begin
                    dec_val = VAL_W'(k + 1);
                end
                dec_seen = 1'b1;
            end
        end
        if (dec_multi) begin
            dec_val = '0;
        end
        dec_blank = !dec_seen;
    end

    always_comb begin
        idx_d         = idx_q;
        blank_acc_d   = blank_acc_q;
        err_acc_d     = err_acc_q;
        blank_count_d = blank_count_q;
        err_count_d   = err_count_q;
        out_valid_d   = out_valid_q;
        out_value_d   = out_value_q;
        out_err_d     = out_err_q;
        out_index_d   = out_index_q;
        out_last_d    = out_last_q;
        frame_done_d  = 1'b0;

        if (clr) begin
            // Frame totals survive an abort; only in-flight state is dropped.
            idx_d       = '0;
            blank_acc_d = '0;
            err_acc_d   = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_value_d = dec_val;
            out_err_d   = dec_multi;
            out_index_d = idx_q;
            out_last_d  = last_cell;
            if (last_cell) begin
                blank_count_d = blank_acc_q + CNT_W'(dec_blank);
                err_count_d   = err_acc_q + CNT_W'(dec_multi);
                blank_acc_d   = '0;
                err_acc_d     = '0;
                idx_d         = '0;
                frame_done_d  = 1'b1;
            end else begin
                blank_acc_d = blank_acc_q + CNT_W'(dec_blank);
                err_acc_d   = err_acc_q + CNT_W'(dec_multi);
                idx_d       = idx_q + IDX_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q         <= '0;
            blank_acc_q   <= '0;
            err_acc_q     <= '0;
            blank_count_q <= '0;
            err_count_q   <= '0;
            out_valid_q   <= 1'b0;
            out_value_q   <= '0;
            out_err_q     <= 1'b0;
            out_index_q   <= '0;
            out_last_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            blank_acc_q   <= blank_acc_d;
            err_acc_q     <= err_acc_d;
            blank_count_q <= blank_count_d;
            err_count_q   <= err_count_d;
            out_valid_q   <= out_valid_d;
            out_value_q   <= out_value_d;
            out_err_q     <= out_err_d;
            out_index_q   <= out_index_d;
            out_last_q    <= out_last_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_value   = out_value_q;
    assign out_err     = out_err_q;
    assign out_index   = out_index_q;
    assign out_last    = out_last_q;
    assign frame_done  = frame_done_q;
    assign blank_count = blank_count_q;
    assign err_count   = err_count_q;

endmodule

// File: doc/sudoku_onehot_stream.md
# sudoku_onehot_stream

Streaming, parametrised one-hot-to-binary cell decoder for the sudoku checker datapath. Accepts one grid cell per handshake as an N-bit one-hot candidate vector, emits the binary digit with a legality flag through a registered output stage, and tracks cell position within an N×N grid. Per-frame blank and illegal-cell totals are reported at end of grid. It generalises the 9-value combinational decoder to any grid order and adds flow control, framing and error reporting.

## Interface
- N, default 9: digits per cell; grid is N×N cells.
- CELLS, default N*N: cells per frame.
- VAL_W, default $clog2(N+1): digit output width, 4 for N=9.
- IDX_W, default $clog2(CELLS): cell index width, 7 for N=9.
- CNT_W, default $clog2(CELLS+1): frame counter width, 7 for N=9.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous frame abort.
- in_valid  in  1  input cell valid.
- in_ready  out  1  input may be accepted.
- in_cell  in  N  one-hot candidate vector; bit k means digit k+1.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_value  out  VAL_W  decoded digit, 0 = blank or illegal.
- out_err  out  1  cell had more than one bit set.
- out_index  out  IDX_W  cell position in frame, 0..CELLS-1.
- out_last  out  1  beat is cell CELLS-1.
- frame_done  out  1  one-cycle pulse at frame end.
- blank_count  out  CNT_W  all-zero cells in last completed frame.
- err_count  out  CNT_W  multi-hot cells in last completed frame.

## Operation
- Decode, strictly by bit index:
  - all zero -> value 0, err 0;
  - exactly bit k set -> value k+1, err 0;
  - two or more bits set -> value 0, err 1.
- No bit pair may be mapped out of order. Bit 5 -> 6, bit 6 -> 7.
- Accept = in_valid && in_ready. On accept, the decode result, current cell index and last flag load into the output register.
- Cell index counter starts at 0 and increments on each accept. After CELLS-1 it wraps to 0.
- Running blank and err accumulators increment on accepted blank and multi-hot cells respectively.
- On accept of cell CELLS-1:
  - blank_count and err_count load accumulator + this cell's contribution;
  - accumulators clear to 0;
  - frame_done pulses.
- blank_count and err_count hold until the next frame completes or reset.
- clr:
  - cell index, accumulators and out_valid go to 0;
  - blank_count and err_count are unchanged;
  - clr wins over a same-cycle accept, and that cell is dropped.
- Output register:
  - holds while out_valid && !out_ready;
  - clears out_valid on out_ready with no new accept;
  - reloads on a simultaneous drain and accept.

## Timing
- in_ready = !out_valid || out_ready, combinational. No other combinational input-to-output path.
- Latency is 1 cycle: a cell accepted at edge t appears on out_* from t+1.
- Full throughput is 1 cell/cycle while out_ready is held high.
- frame_done asserts in the same cycle out_valid && out_last first asserts for that beat, for exactly 1 cycle, even if the beat stalls. blank_count and err_count are updated at that same edge.
- Reset values:
  - out_valid, out_value, out_err, out_index, out_last, frame_done = 0;
  - blank_count, err_count = 0;
  - in_ready = 1.
- rst mid-frame discards all partial state. The next accepted cell is index 0.

## Test plan
- N=9, each one-hot in_cell 9'h001..9'h100 with out_ready=1 -> out_value 1..9 in order, out_err 0, 1-cycle latency. Bit 5 -> 6 and bit 6 -> 7 are checked explicitly.
- in_cell 9'h000 -> value 0, err 0. 9'h060 and 9'h1FF -> value 0, err 1.
- Full 81-cell frame with 5 blanks and 2 multi-hot cells, back to back -> out_last and frame_done only on index 80, blank_count=5, err_count=2. The next frame restarts at index 0.
- Hold out_ready=0 for 3 cycles mid-stream -> in_ready low, out_* stable, no cell lost or duplicated. Release -> stream resumes in order.
- Assert clr at cell 40 together with in_valid -> that cell is dropped, next accepted index is 0, prior frame totals are held.
- rst asserted asynchronously mid-frame -> all outputs 0 immediately, in_ready=1. Parameter N=16 -> bit 15 decodes to 16, VAL_W=5, out_last at index 255.
